// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard unit: load-use / RAW stalls and branch flushes.
// Optional macro ID_EX_FWD_EN enables E-stage operand forwarding; otherwise RAW hazards stall.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ResultSrcD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            JalrD,
  input  logic            ALUSrcD,
  input  logic            Op5D,
  input  logic [1:0]      StoreD,
  input  logic [2:0]      LoadD,
  input  logic [3:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [RA_W-1:0] Rs1D,
  input  logic [RA_W-1:0] Rs2D,
  input  logic [RA_W-1:0] RdD,
  input  logic            PCSrcE,
  input  logic [RA_W-1:0] RdM,
  input  logic [RA_W-1:0] RdW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  output logic [1:0]      ResultSrcE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            JalrE,
  output logic            ALUSrcE,
  output logic            Op5E,
  output logic [1:0]      StoreE,
  output logic [2:0]      LoadE,
  output logic [3:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [RA_W-1:0] Rs1E,
  output logic [RA_W-1:0] Rs2E,
  output logic [RA_W-1:0] RdE,
  output logic            ValidE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE
);

  logic load_e;
  logic rd_e_hit;
  logic lw_stall;
  logic stall;
  logic flush_e;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign load_e   = ValidE & (ResultSrcE == 2'b01);
  assign rd_e_hit = (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign lw_stall = load_e & rd_e_hit;

`ifdef ID_EX_FWD_EN
  assign stall = lw_stall;

  // M-stage producer is younger than W, so it wins when both match.
  always_comb begin
    fwd_a = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
      fwd_a = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
      fwd_b = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
      fwd_b = 2'b01;
  end
`else
  logic raw_e;
  logic raw_m;
  logic unused_w;

  // Write-first register file: a W-stage producer never needs a stall.
  assign unused_w = ^{RdW, RegWriteW};
  assign raw_e    = ValidE & RegWriteE & rd_e_hit;
  assign raw_m    = RegWriteM & (RdM != '0) & ((RdM == Rs1D) | (RdM == Rs2D));
  assign stall    = lw_stall | raw_e | raw_m;
  assign fwd_a    = 2'b00;
  assign fwd_b    = 2'b00;
`endif

  assign flush_e = PCSrcE | stall;

  // Hazard outputs stay quiet while reset is asserted, whatever the M/W inputs show.
  assign StallF    = rst_n & stall;
  assign StallD    = rst_n & stall;
  assign FlushD    = rst_n & PCSrcE;
  assign ForwardAE = rst_n ? fwd_a : 2'b00;
  assign ForwardBE = rst_n ? fwd_b : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ResultSrcE  <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      JalrE       <= 1'b0;
      ALUSrcE     <= 1'b0;
      Op5E        <= 1'b0;
      StoreE      <= '0;
      LoadE       <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      ImmExtE     <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      ValidE      <= 1'b0;
    end else begin
      ALUSrcE     <= ALUSrcD;
      Op5E        <= Op5D;
      ALUControlE <= ALUControlD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      ImmExtE     <= ImmExtD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      if (flush_e) begin
        ResultSrcE <= '0;
        RegWriteE  <= 1'b0;
        MemWriteE  <= 1'b0;
        JumpE      <= 1'b0;
        BranchE    <= 1'b0;
        JalrE      <= 1'b0;
        StoreE     <= '0;
        LoadE      <= '0;
        ValidE     <= 1'b0;
      end else begin
        ResultSrcE <= ResultSrcD;
        RegWriteE  <= RegWriteD;
        MemWriteE  <= MemWriteD;
        JumpE      <= JumpD;
        BranchE    <= BranchD;
        JalrE      <= JalrD;
        StoreE     <= StoreD;
        LoadE      <= LoadD;
        ValidE     <= 1'b1;
      end
    end
  end

endmodule
